// File: rtl/cordic_angle_pkg.sv
// Shared angle constants, datapath widths and the CORDIC arctangent ROM for the
// vectoring-mode angle estimator.
package cordic_angle_pkg;

  typedef logic signed [19:0] xy_t;
  typedef logic signed [18:0] z_t;
  typedef logic signed [19:0] ang_t;

  // Angles in rad*32768; TWO_PI is exactly 4*HP so quadrant wrap is lossless.
  localparam ang_t HP       = 20'sd51472;
  localparam ang_t PI       = 20'sd102944;
  localparam ang_t THREE_HP = 20'sd154416;
  localparam ang_t TWO_PI   = 20'sd205888;
  localparam z_t   Z_MAX    = 19'sd51471;

  function automatic z_t atan_rom(input logic [3:0] idx);
    z_t r;
    case (idx)
      4'd0:    r = 19'sd25736;
      4'd1:    r = 19'sd15193;
      4'd2:    r = 19'sd8027;
      4'd3:    r = 19'sd4075;
      4'd4:    r = 19'sd2045;
      4'd5:    r = 19'sd1024;
      4'd6:    r = 19'sd512;
      4'd7:    r = 19'sd256;
      4'd8:    r = 19'sd128;
      4'd9:    r = 19'sd64;
      4'd10:   r = 19'sd32;
      4'd11:   r = 19'sd16;
      4'd12:   r = 19'sd8;
      4'd13:   r = 19'sd4;
      4'd14:   r = 19'sd2;
      default: r = 19'sd1;
    endcase
    return r;
  endfunction

  function automatic ang_t quad_base(input logic [1:0] q);
    ang_t r;
    case (q)
      2'd0:    r = '0;
      2'd1:    r = HP;
      2'd2:    r = PI;
      default: r = THREE_HP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_vector_core.sv
// Quadrant pre-rotation plus iterative vectoring CORDIC; z_out holds the clamped
// in-quadrant angle once done has been seen.
module cordic_vector_core
  import cordic_angle_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] cx_in,
  input  logic signed [15:0] cy_in,
  output logic               done,
  output logic [1:0]         quad,
  output logic [15:0]        z_out
);

  localparam logic [3:0] LAST = 4'(ITER - 1);

  xy_t        x_q, x_d, y_q, y_d;
  xy_t        cx_w, cy_w, x_sh, y_sh;
  z_t         z_q, z_d;
  logic [3:0] i_q, i_d;
  logic       busy_q, busy_d;
  logic       zero_q, zero_d;
  logic [1:0] quad_q, quad_d;
  logic       x_pos, y_pos, is_zero;

  function automatic logic [15:0] clamp_z(input z_t z);
    logic [15:0] r;
    if (z[18])          r = '0;
    else if (z > Z_MAX) r = 16'(Z_MAX);
    else                r = 16'(z);
    return r;
  endfunction

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    i_d    = i_q;
    busy_d = busy_q;
    zero_d = zero_q;
    quad_d = quad_q;
    // Widen before negating so -32768 maps to +32768 without wrapping.
    cx_w    = $signed({{4{cx_in[15]}}, cx_in});
    cy_w    = $signed({{4{cy_in[15]}}, cy_in});
    x_sh    = x_q >>> i_q;
    y_sh    = y_q >>> i_q;
    x_pos   = !cx_in[15] && (cx_in != 16'sd0);
    y_pos   = !cy_in[15] && (cy_in != 16'sd0);
    is_zero = (cx_in == 16'sd0) && (cy_in == 16'sd0);

    if (start) begin
      z_d    = '0;
      i_d    = '0;
      busy_d = 1'b1;
      zero_d = is_zero;
      if (is_zero) begin
        quad_d = 2'd0; x_d = '0;    y_d = '0;
      end else if (x_pos && !cy_in[15]) begin
        quad_d = 2'd0; x_d = cx_w;  y_d = cy_w;
      end else if (!x_pos && y_pos) begin
        quad_d = 2'd1; x_d = cy_w;  y_d = -cx_w;
      end else if (cx_in[15] && !y_pos) begin
        quad_d = 2'd2; x_d = -cx_w; y_d = -cy_w;
      end else begin
        quad_d = 2'd3; x_d = -cy_w; y_d = cx_w;
      end
    end else if (busy_q) begin
      if (!y_q[19]) begin
        x_d = x_q + y_sh;
        y_d = y_q - x_sh;
        z_d = z_q + atan_rom(i_q);
      end else begin
        x_d = x_q - y_sh;
        y_d = y_q + x_sh;
        z_d = z_q - atan_rom(i_q);
      end
      if (i_q == LAST) busy_d = 1'b0;
      else             i_d    = i_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      i_q    <= '0;
      busy_q <= 1'b0;
      zero_q <= 1'b0;
      quad_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      i_q    <= i_d;
      busy_q <= busy_d;
      zero_q <= zero_d;
      quad_q <= quad_d;
    end
  end

  // The zero vector would otherwise accumulate every atan entry.
  assign done  = busy_q && (i_q == LAST);
  assign quad  = quad_q;
  assign z_out = zero_q ? 16'd0 : clamp_z(z_q);

endmodule

// File: rtl/cordic_angle_calc_kf.sv
// Full-circle vector angle via CORDIC, smoothed by a fixed-gain Kalman filter and
// reported as quadrant plus in-quadrant offset with a one-cycle valid strobe.
module cordic_angle_calc_kf
  import cordic_angle_pkg::*;
#(
  parameter int ITER    = 16,
  parameter int KF_GAIN = 8192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] cx_in,
  input  logic signed [15:0] cy_in,
  output logic signed [16:0] theta_1st_quad,
  output logic [1:0]         quadrant,
  output logic               angle_valid
);

  localparam logic [2:0] ST_LOAD = 3'd0;
  localparam logic [2:0] ST_ITER = 3'd1;
  localparam logic [2:0] ST_MEAS = 3'd2;
  localparam logic [2:0] ST_UPD  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  localparam logic signed [39:0] K_S = 40'(KF_GAIN);

  logic [2:0]         state_q, state_d;
  ang_t               est_q, est_d, meas_q, meas_d, dlt_q, dlt_d;
  ang_t               meas_now, est_n;
  logic               first_q, first_d;
  logic signed [16:0] theta_q, theta_d;
  logic [1:0]         quad_q, quad_d, q_n;
  logic               valid_q, valid_d;
  logic               core_done;
  logic [1:0]         core_quad;
  logic [15:0]        core_z;

  function automatic ang_t wrap_innov(input ang_t d);
    ang_t r;
    if (d > PI)        r = d - TWO_PI;
    else if (d <= -PI) r = d + TWO_PI;
    else               r = d;
    return r;
  endfunction

  function automatic ang_t wrap_angle(input ang_t a);
    ang_t r;
    if (a >= TWO_PI) r = a - TWO_PI;
    else if (a[19])  r = a + TWO_PI;
    else             r = a;
    return r;
  endfunction

  // Arithmetic shift floors toward -inf, matching the filter's reference rounding.
  function automatic ang_t kf_delta(input ang_t d);
    logic signed [39:0] d_ext, prod;
    d_ext = $signed({{20{d[19]}}, d});
    prod  = d_ext * K_S;
    return ang_t'(prod >>> 15);
  endfunction

  cordic_vector_core #(.ITER(ITER)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == ST_LOAD),
    .cx_in (cx_in),
    .cy_in (cy_in),
    .done  (core_done),
    .quad  (core_quad),
    .z_out (core_z)
  );

  always_comb begin
    state_d  = state_q;
    est_d    = est_q;
    first_d  = first_q;
    meas_d   = meas_q;
    dlt_d    = dlt_q;
    theta_d  = theta_q;
    quad_d   = quad_q;
    valid_d  = 1'b0;
    meas_now = quad_base(core_quad) + $signed({4'b0000, core_z});
    est_n    = first_q ? meas_q : wrap_angle(est_q + kf_delta(dlt_q));
    if (est_n >= THREE_HP) q_n = 2'd3;
    else if (est_n >= PI)  q_n = 2'd2;
    else if (est_n >= HP)  q_n = 2'd1;
    else                   q_n = 2'd0;

    case (state_q)
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: if (core_done) state_d = ST_MEAS;
      ST_MEAS: begin
        meas_d  = meas_now;
        dlt_d   = wrap_innov(meas_now - est_q);
        state_d = ST_UPD;
      end
      ST_UPD: begin
        est_d   = est_n;
        first_d = 1'b0;
        quad_d  = q_n;
        theta_d = 17'(est_n - quad_base(q_n));
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT:  state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      est_q   <= '0;
      first_q <= 1'b1;
      meas_q  <= '0;
      dlt_q   <= '0;
      theta_q <= '0;
      quad_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      est_q   <= est_d;
      first_q <= first_d;
      meas_q  <= meas_d;
      dlt_q   <= dlt_d;
      theta_q <= theta_d;
      quad_q  <= quad_d;
      valid_q <= valid_d;
    end
  end

  assign theta_1st_quad = theta_q;
  assign quadrant       = quad_q;
  assign angle_valid    = valid_q;

endmodule

// File: tb/tb_cordic_angle_calc_kf.sv
// Directed scoreboard bench: a bypass-gain (K=1.0) and a K=0.25 instance share the
// same stimulus; expected angles are queued at drive time and popped on angle_valid.
module tb_cordic_angle_calc_kf;

  localparam int ITER = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] cx, cy;
  logic signed [16:0] th_a, th_b;
  logic [1:0]         q_a, q_b;
  logic               v_a, v_b;

  typedef struct {
    int id;
    bit chk;
    int q;
    int th;
    int tol;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   checks = 0;
  int   errors = 0;
  int   n_sent = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_angle_calc_kf #(.ITER(ITER), .KF_GAIN(32768)) dut_a (
    .clk(clk), .rst(rst), .cx_in(cx), .cy_in(cy),
    .theta_1st_quad(th_a), .quadrant(q_a), .angle_valid(v_a)
  );

  cordic_angle_calc_kf #(.ITER(ITER), .KF_GAIN(8192)) dut_b (
    .clk(clk), .rst(rst), .cx_in(cx), .cy_in(cy),
    .theta_1st_quad(th_b), .quadrant(q_b), .angle_valid(v_b)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
    bit ok;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // Scoreboard consumers for both instances.
  always @(negedge clk) begin
    exp_t e;
    if (v_a === 1'b1) begin
      if (sb_a.size() == 0) check_eq("A unexpected valid", int'(v_a), 0);
      else begin
        e = sb_a.pop_front();
        if (e.chk) begin
          check_eq($sformatf("A#%0d quadrant", e.id), int'(q_a), e.q);
          check_tol($sformatf("A#%0d theta", e.id), int'(th_a), e.th, e.tol);
        end
      end
    end
    if (v_b === 1'b1) begin
      if (sb_b.size() == 0) check_eq("B unexpected valid", int'(v_b), 0);
      else begin
        e = sb_b.pop_front();
        if (e.chk) begin
          check_eq($sformatf("B#%0d quadrant", e.id), int'(q_b), e.q);
          check_tol($sformatf("B#%0d theta", e.id), int'(th_b), e.th, e.tol);
        end
      end
    end
  end

  task automatic apply(input int x, input int y,
                       input bit ca, input int qa, input int ta, input int tola,
                       input bit cb, input int qb, input int tbv, input int tolb);
    exp_t e;
    cx = 16'(x);
    cy = 16'(y);
    n_sent++;
    e.id = n_sent; e.chk = ca; e.q = qa; e.th = ta;  e.tol = tola;
    sb_a.push_back(e);
    e.chk = cb;    e.q = qb;  e.th = tbv; e.tol = tolb;
    sb_b.push_back(e);
  endtask

  task automatic wait_valid(output int vc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (v_a !== 1'b1 && n < 60);
    vc = cyc;
    check_eq("valid within cycle budget", int'(v_a === 1'b1), 1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " theta A"}, int'(th_a), 0);
    check_eq({tag, " quad A"},  int'(q_a), 0);
    check_eq({tag, " valid A"}, int'(v_a), 0);
    check_eq({tag, " theta B"}, int'(th_b), 0);
    check_eq({tag, " quad B"},  int'(q_b), 0);
    check_eq({tag, " valid B"}, int'(v_b), 0);
  endtask

  initial begin
    int n, vc, prev, c0;
    rst = 1'b1;
    cx  = '0;
    cy  = '0;
    repeat (5) @(negedge clk);
    check_idle("reset");

    // First sample is the zero vector; both filters start from est=meas=0.
    apply(0, 0, 1'b1, 0, 0, 0, 1'b1, 0, 0, 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (v_a !== 1'b1 && n < 40);
    check_eq("first valid latency", n, ITER + 3);
    @(posedge clk);
    #1;
    check_eq("valid pulse width", int'(v_a), 0);

    apply(16384, 0, 1'b1, 0, 0, 4, 1'b1, 0, 0, 4);
    wait_valid(prev);
    apply(0, 16384, 1'b1, 1, 0, 4, 1'b1, 0, 12868, 2);
    wait_valid(vc);
    check_eq("sample interval", vc - prev, ITER + 4);
    prev = vc;
    apply(-10000, -10000, 1'b1, 2, 25736, 4, 1'b0, 0, 0, 0);
    wait_valid(vc);
    check_eq("sample interval", vc - prev, ITER + 4);
    prev = vc;
    apply(-32768, -32768, 1'b1, 2, 25736, 4, 1'b0, 0, 0, 0);
    wait_valid(vc);
    check_eq("sample interval", vc - prev, ITER + 4);
    prev = vc;
    apply(32767, -32768, 1'b1, 3, 25736, 4, 1'b0, 0, 0, 0);
    wait_valid(vc);
    check_eq("sample interval", vc - prev, ITER + 4);
    prev = vc;
    apply(0, 0, 1'b1, 0, 0, 0, 1'b0, 0, 0, 0);
    wait_valid(vc);
    check_eq("sample interval", vc - prev, ITER + 4);

    // Wrap across 2*pi: estimate creeps from just below 2*pi toward +200 LSB.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("re-reset");
    apply(16384, -100, 1'b1, 3, 51272, 4, 1'b1, 3, 51272, 4);
    rst = 1'b0;
    wait_valid(vc);
    apply(16384, 100, 1'b1, 0, 200, 4, 1'b1, 3, 51372, 10);
    wait_valid(vc);
    apply(16384, 100, 1'b1, 0, 200, 4, 1'b1, 3, 51447, 10);
    wait_valid(vc);
    apply(16384, 100, 1'b1, 0, 200, 4, 1'b0, 0, 0, 0);
    wait_valid(vc);
    apply(16384, 100, 1'b1, 0, 200, 4, 1'b1, 0, 73, 12);
    wait_valid(vc);
    apply(16384, 100, 1'b1, 0, 200, 4, 1'b1, 0, 104, 12);
    wait_valid(vc);

    // Abort mid-iteration; the next result must be unfiltered (est=meas).
    cx = 16'sd0;
    cy = 16'sd16384;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("mid-iter reset");
    apply(0, 16384, 1'b1, 1, 0, 4, 1'b1, 1, 0, 4);
    c0 = cyc;
    rst = 1'b0;
    wait_valid(vc);
    check_eq("latency after abort", vc - c0, ITER + 3);

    @(negedge clk);
    check_eq("scoreboard drained", sb_a.size() + sb_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
